// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width, ALU
// command codes and the arbiter state encoding.
package alu_arbiter_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_AND = 3'd2;
    localparam logic [2:0] CMD_OR  = 3'd3;
    localparam logic [2:0] CMD_XOR = 3'd4;
    localparam logic [2:0] CMD_NOT = 3'd5;
    localparam logic [2:0] CMD_SHL = 3'd6;
    localparam logic [2:0] CMD_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters, with
// one operation in flight and a bounded wait for the ALU result.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DW      = DATA_WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req0_valid,
    input  logic [DW-1:0] i_req0_a,
    input  logic [DW-1:0] i_req0_b,
    input  logic [2:0]    i_req0_cmd,
    output logic          o_req0_ready,
    input  logic          i_req1_valid,
    input  logic [DW-1:0] i_req1_a,
    input  logic [DW-1:0] i_req1_b,
    input  logic [2:0]    i_req1_cmd,
    output logic          o_req1_ready,
    output logic          o_resp0_valid,
    output logic [DW-1:0] o_resp0_res,
    output logic          o_resp0_err,
    input  logic          i_resp0_ready,
    output logic          o_resp1_valid,
    output logic [DW-1:0] o_resp1_res,
    output logic          o_resp1_err,
    input  logic          i_resp1_ready,
    output logic [DW-1:0] o_alu_a,
    output logic [DW-1:0] o_alu_b,
    output logic [2:0]    o_alu_cmd,
    output logic          o_alu_valid,
    input  logic          i_alu_ready,
    input  logic          i_alu_valid,
    input  logic [DW-1:0] i_alu_result
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t       state;
    logic             owner;
    logic             last_grant;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    logic [2:0]       cmd_q;
    logic [DW-1:0]    res_q;
    logic             err_q;
    logic             alu_vld_q;
    logic             resp0_vld_q;
    logic             resp1_vld_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             any_req;
    logic             grant;
    logic             owner_ready;

    // grant is the index of the requester served this cycle; on a tie the
    // one not served last wins, a lone requester always wins.
    always_comb begin
        any_req = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = i_req1_valid;
        end
    end

    assign o_req0_ready = (state == ST_IDLE) && i_req0_valid && !grant;
    assign o_req1_ready = (state == ST_IDLE) && i_req1_valid && grant;

    assign wait_cnt_nxt = wait_cnt + CNT_W'(1);
    assign owner_ready  = owner ? i_resp1_ready : i_resp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            cmd_q       <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            alu_vld_q   <= 1'b0;
            resp0_vld_q <= 1'b0;
            resp1_vld_q <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner     <= grant;
                        a_q       <= grant ? i_req1_a   : i_req0_a;
                        b_q       <= grant ? i_req1_b   : i_req0_b;
                        cmd_q     <= grant ? i_req1_cmd : i_req0_cmd;
                        alu_vld_q <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_alu_ready) begin
                        alu_vld_q <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt_nxt;
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (i_alu_valid) begin
                        res_q       <= i_alu_result;
                        err_q       <= 1'b0;
                        resp0_vld_q <= ~owner;
                        resp1_vld_q <= owner;
                        state       <= ST_RESP;
                    end else if (wait_cnt_nxt == CNT_MAX) begin
                        res_q       <= '0;
                        err_q       <= 1'b1;
                        resp0_vld_q <= ~owner;
                        resp1_vld_q <= owner;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (owner_ready) begin
                        last_grant  <= owner;
                        resp0_vld_q <= 1'b0;
                        resp1_vld_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_alu_a       = a_q;
    assign o_alu_b       = b_q;
    assign o_alu_cmd     = cmd_q;
    assign o_alu_valid   = alu_vld_q;
    assign o_resp0_valid = resp0_vld_q;
    assign o_resp1_valid = resp1_vld_q;
    assign o_resp0_res   = res_q;
    assign o_resp1_res   = res_q;
    assign o_resp0_err   = err_q;
    assign o_resp1_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: queue-fed requesters, a behavioural ALU and a
// scoreboard of expected responses filled at request acceptance.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int TO = 16;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    cmd;
    } op_t;

    typedef struct {
        int            owner;
        logic [DW-1:0] res;
        logic          err;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0][DW-1:0]  req_a;
    logic [1:0][DW-1:0]  req_b;
    logic [1:0][2:0]     req_cmd;
    logic [1:0]          req_ready;
    logic [1:0]          resp_valid;
    logic [1:0][DW-1:0]  resp_res;
    logic [1:0]          resp_err;
    logic [1:0]          resp_ready;
    logic [DW-1:0]       alu_a;
    logic [DW-1:0]       alu_b;
    logic [2:0]          alu_cmd;
    logic                alu_vld;
    logic                alu_rdy;
    logic                alu_res_vld;
    logic [DW-1:0]       alu_result;

    alu_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req0_valid  (req_valid[0]),
        .i_req0_a      (req_a[0]),
        .i_req0_b      (req_b[0]),
        .i_req0_cmd    (req_cmd[0]),
        .o_req0_ready  (req_ready[0]),
        .i_req1_valid  (req_valid[1]),
        .i_req1_a      (req_a[1]),
        .i_req1_b      (req_b[1]),
        .i_req1_cmd    (req_cmd[1]),
        .o_req1_ready  (req_ready[1]),
        .o_resp0_valid (resp_valid[0]),
        .o_resp0_res   (resp_res[0]),
        .o_resp0_err   (resp_err[0]),
        .i_resp0_ready (resp_ready[0]),
        .o_resp1_valid (resp_valid[1]),
        .o_resp1_res   (resp_res[1]),
        .o_resp1_err   (resp_err[1]),
        .i_resp1_ready (resp_ready[1]),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_cmd     (alu_cmd),
        .o_alu_valid   (alu_vld),
        .i_alu_ready   (alu_rdy),
        .i_alu_valid   (alu_res_vld),
        .i_alu_result  (alu_result)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    int   grant_log[$];
    int   alu_runs[$];

    int   acc_cnt[2];
    int   t_acc[2];
    int   t_hs[2];
    int   resp_first[2];
    int   resp_run_last[2];
    logic [DW-1:0] last_res[2];
    logic          last_err[2];

    int   alu_stall;
    int   alu_lat;
    bit   spur;
    int   resp_hold[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [2:0] cmd);
        logic [DW-1:0] r;
        case (cmd)
            CMD_ADD: r = a + b;
            CMD_SUB: r = a - b;
            CMD_AND: r = a & b;
            CMD_OR:  r = a | b;
            CMD_XOR: r = a ^ b;
            CMD_NOT: r = ~a;
            CMD_SHL: r = a << 1;
            default: r = a >> 1;
        endcase
        return r;
    endfunction

    task automatic push_op(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [2:0] cmd);
        op_t o;
        o.a = a;
        o.b = b;
        o.cmd = cmd;
        if (n == 0) q0.push_back(o);
        else        q1.push_back(o);
    endtask

    // Behavioural ALU: stalls ready for alu_stall ISSUE cycles, answers on
    // WAIT cycle alu_lat (0 = never), optionally drives stray valids when idle.
    initial begin
        logic [DW-1:0] op_a, op_b;
        logic [2:0]    op_cmd;
        int            issue_n, wait_n;
        bit            in_wait;
        alu_rdy = 1'b0; alu_res_vld = 1'b0; alu_result = '0;
        issue_n = 0; wait_n = 0; in_wait = 0;
        op_a = '0; op_b = '0; op_cmd = '0;
        forever begin
            @(negedge clk);
            alu_rdy = 1'b0; alu_res_vld = 1'b0; alu_result = '0;
            if (reset) begin
                in_wait = 0;
                issue_n = 0;
            end else if (alu_vld) begin
                issue_n++;
                if (issue_n > alu_stall) begin
                    alu_rdy = 1'b1;
                    issue_n = 0;
                    in_wait = 1;
                    wait_n  = 0;
                    op_a = alu_a; op_b = alu_b; op_cmd = alu_cmd;
                end
            end else if (in_wait) begin
                wait_n++;
                if (alu_lat != 0 && wait_n == alu_lat) begin
                    alu_res_vld = 1'b1;
                    alu_result  = alu_fn(op_a, op_b, op_cmd);
                    in_wait = 0;
                end else if (wait_n >= TO) begin
                    in_wait = 0;
                end
            end else if (spur) begin
                alu_res_vld = 1'b1;
                alu_result  = 8'hAB;
            end
        end
    end

    // Requester and response-consumer driver, updated just after each edge.
    initial begin
        int pop_cnt[2];
        int rh[2];
        pop_cnt = '{0, 0};
        rh = '{0, 0};
        req_valid = '0; req_a = '0; req_b = '0; req_cmd = '0; resp_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            while (pop_cnt[0] < acc_cnt[0]) begin
                if (q0.size() != 0) q0.delete(0);
                pop_cnt[0]++;
            end
            while (pop_cnt[1] < acc_cnt[1]) begin
                if (q1.size() != 0) q1.delete(0);
                pop_cnt[1]++;
            end
            req_valid[0] = (q0.size() != 0);
            if (q0.size() != 0) begin
                req_a[0] = q0[0].a; req_b[0] = q0[0].b; req_cmd[0] = q0[0].cmd;
            end
            req_valid[1] = (q1.size() != 0);
            if (q1.size() != 0) begin
                req_a[1] = q1[0].a; req_b[1] = q1[0].b; req_cmd[1] = q1[0].cmd;
            end
            for (int n = 0; n < 2; n++) begin
                if (resp_valid[n]) begin
                    rh[n]++;
                    resp_ready[n] = (rh[n] > resp_hold[n]);
                end else begin
                    rh[n] = 0;
                    resp_ready[n] = 1'b0;
                end
            end
        end
    end

    // Monitor: grants feed the scoreboard, handshaken responses drain it.
    initial begin
        int            alu_run;
        int            rrun[2];
        logic [DW-1:0] pa, pb;
        logic [2:0]    pc;
        logic [DW-1:0] pres[2];
        logic          perr[2];
        exp_t          e;
        alu_run = 0; rrun = '{0, 0};
        pa = '0; pb = '0; pc = '0;
        pres = '{'0, '0}; perr = '{1'b0, 1'b0};
        acc_cnt = '{0, 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                alu_run = 0;
                rrun = '{0, 0};
            end else begin
                if (req_ready != 2'b00) check("ready_onehot", $countones(req_ready), 1);
                for (int n = 0; n < 2; n++) begin
                    if (req_ready[n]) begin
                        check($sformatf("ready_needs_valid%0d", n), req_valid[n], 1);
                        grant_log.push_back(n);
                        t_acc[n] = cyc;
                        acc_cnt[n]++;
                        e.owner = n;
                        e.err   = (alu_lat == 0 || alu_lat > TO);
                        e.res   = e.err ? '0 : alu_fn(req_a[n], req_b[n], req_cmd[n]);
                        sb.push_back(e);
                    end
                    if (req_valid[n] && (alu_vld || resp_valid != 2'b00))
                        check($sformatf("busy_ready%0d", n), req_ready[n], 0);
                end
                if (alu_vld) begin
                    if (alu_run > 0) begin
                        check("alu_a_stable", alu_a, pa);
                        check("alu_b_stable", alu_b, pb);
                        check("alu_cmd_stable", alu_cmd, pc);
                    end
                    alu_run++;
                    pa = alu_a; pb = alu_b; pc = alu_cmd;
                end else if (alu_run > 0) begin
                    alu_runs.push_back(alu_run);
                    alu_run = 0;
                end
                if (resp_valid != 2'b00) check("resp_onehot", $countones(resp_valid), 1);
                for (int n = 0; n < 2; n++) begin
                    if (resp_valid[n]) begin
                        if (rrun[n] == 0) begin
                            resp_first[n] = cyc;
                        end else begin
                            check($sformatf("resp%0d_res_stable", n), resp_res[n], pres[n]);
                            check($sformatf("resp%0d_err_stable", n), resp_err[n], perr[n]);
                        end
                        rrun[n]++;
                        pres[n] = resp_res[n];
                        perr[n] = resp_err[n];
                        if (resp_ready[n]) begin
                            t_hs[n] = cyc;
                            last_res[n] = resp_res[n];
                            last_err[n] = resp_err[n];
                            check("resp_pending", sb.size() != 0, 1);
                            if (sb.size() != 0) begin
                                e = sb.pop_front();
                                check("resp_owner", n, e.owner);
                                check($sformatf("resp%0d_res", n), resp_res[n], e.res);
                                check($sformatf("resp%0d_err", n), resp_err[n], e.err);
                            end
                        end
                    end else if (rrun[n] > 0) begin
                        resp_run_last[n] = rrun[n];
                        rrun[n] = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string tag, input int max_cyc);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || req_valid != 2'b00)
               && k < max_cyc) begin
            @(posedge clk);
            #2;
            k++;
        end
        check({tag, "_drained"}, sb.size() + q0.size() + q1.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_accept(input int max_cyc);
        int k = 0;
        while (sb.size() == 0 && k < max_cyc) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("accept_seen", sb.size() != 0, 1);
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_req_ready"}, req_ready, 0);
        check({pfx, "_resp_valid"}, resp_valid, 0);
        check({pfx, "_resp_err"}, resp_err, 0);
        check({pfx, "_resp0_res"}, resp_res[0], 0);
        check({pfx, "_resp1_res"}, resp_res[1], 0);
        check({pfx, "_alu_valid"}, alu_vld, 0);
        check({pfx, "_alu_a"}, alu_a, 0);
        check({pfx, "_alu_b"}, alu_b, 0);
        check({pfx, "_alu_cmd"}, alu_cmd, 0);
    endtask

    initial begin
        reset = 1'b1;
        alu_stall = 0; alu_lat = 1; spur = 0; resp_hold = '{0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Tie: three ops on each requester, alternating from requester 0.
        alu_lat = 2;
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            push_op(0, 8'h10 + 8'(i), 8'h01, CMD_ADD);
            push_op(1, 8'h30 + 8'(i), 8'h03, CMD_SUB);
        end
        wait_idle("tie", 300);
        check("tie_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("tie_order%0d", i), grant_log[i], i % 2);

        // Lone requester 1 wins although the pointer favours requester 0.
        grant_log.delete();
        push_op(1, 8'h7F, 8'h01, CMD_ADD);
        wait_idle("single1", 50);
        check("single1_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
        check("single1_res", last_res[1], 8'h80);

        // Minimum latency XOR on requester 0.
        alu_lat = 1;
        push_op(0, 8'h0F, 8'hF0, CMD_XOR);
        wait_idle("lat", 50);
        check("lat_cycles", resp_first[0] - t_acc[0], 3);
        check("lat_res", last_res[0], 8'hFF);
        check("lat_err", last_err[0], 0);

        // Backpressure on both ALU issue and response consumption.
        alu_stall = 5; resp_hold[0] = 4;
        alu_runs.delete();
        grant_log.delete();
        push_op(0, 8'hF3, 8'h3C, CMD_AND);
        wait_accept(20);
        push_op(1, 8'h12, 8'h40, CMD_OR);
        wait_idle("bp", 100);
        check("bp_issue_cycles", alu_runs.size() > 0 ? alu_runs[0] : 0, 6);
        check("bp_resp0_cycles", resp_run_last[0], 5);
        check("bp_req1_after_resp0", t_acc[1] > t_hs[0], 1);
        check("bp_res0", last_res[0], 8'h30);
        check("bp_res1", last_res[1], 8'h52);
        alu_stall = 0; resp_hold[0] = 0;

        // Timeout with stray ALU valids outside WAIT, then a result on the last cycle.
        alu_lat = 0; spur = 1; resp_hold[0] = 3;
        push_op(0, 8'h05, 8'h03, CMD_SUB);
        wait_idle("to", 100);
        check("to_cycles", resp_first[0] - t_acc[0], 18);
        check("to_res", last_res[0], 0);
        check("to_err", last_err[0], 1);
        resp_hold[0] = 0; spur = 0;
        alu_lat = TO;
        push_op(1, 8'hAA, 8'h55, CMD_XOR);
        wait_idle("edge", 100);
        check("edge_cycles", resp_first[1] - t_acc[1], 18);
        check("edge_res", last_res[1], 8'hFF);
        check("edge_err", last_err[1], 0);

        // Reset while waiting on the ALU aborts the operation silently.
        alu_lat = 0;
        push_op(0, 8'h21, 8'h12, CMD_ADD);
        wait_accept(20);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_quiet("mid_rst");
        repeat (25) @(posedge clk);
        #2;
        check("mid_rst_no_resp", resp_valid, 0);
        alu_lat = 1;
        grant_log.delete();
        push_op(0, 8'h01, 8'h02, CMD_OR);
        push_op(1, 8'h04, 8'h08, CMD_OR);
        wait_idle("post_rst", 50);
        check("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        check("post_rst_second", grant_log.size() > 1 ? grant_log[1] : -1, 1);

        check("sb_final", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default `DATA_WIDTH, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles waited for ALU result.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_req0_valid / i_req1_valid  input  1 each  requester N has an operation pending.
REQ-006 SHALL have ports i_reqN_a, i_reqN_b  input  DW  operands of requester N.
REQ-007 SHALL have ports i_reqN_cmd  input  3  ALU command of requester N.
REQ-008 SHALL have ports o_reqN_ready  output  1  request N accepted this cycle.
REQ-009 SHALL have ports o_respN_valid  output  1  response for requester N held.
REQ-010 SHALL have ports o_respN_res  output  DW, o_respN_err  output  1  result and timeout flag.
REQ-011 SHALL have ports i_respN_ready  input  1  requester N consumes response.
REQ-012 SHALL have ports o_alu_a, o_alu_b  output  DW; o_alu_cmd  output  3; o_alu_valid  output  1  command to the ALU.
REQ-013 SHALL have ports i_alu_ready  input  1; i_alu_valid  input  1; i_alu_result  input  DW  ALU handshake and result.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one operation in flight.
REQ-015 IDLE: if any i_reqN_valid, SHALL grant one requester, assert its o_reqN_ready combinationally that cycle, latch a/b/cmd and owner at the edge, go ISSUE.
REQ-016 Both valid in IDLE: SHALL grant the requester not granted last (round-robin); single valid: grant it regardless of pointer.
REQ-017 o_reqN_ready SHALL be high only in IDLE and only for the granted requester; never both.
REQ-018 ISSUE: SHALL drive latched operands on o_alu_*, o_alu_valid=1; on edge with i_alu_ready=1 go WAIT, clear wait counter.
REQ-019 WAIT: o_alu_valid=0; on i_alu_valid=1 SHALL capture i_alu_result, err=0, go RESP.
REQ-020 WAIT: counter increments per cycle; when counter reaches TIMEOUT without i_alu_valid SHALL set result=0, err=1, go RESP.
REQ-021 i_alu_valid in the same cycle the counter reaches TIMEOUT: result wins, err=0.
REQ-022 i_alu_valid outside WAIT SHALL be ignored.
REQ-023 RESP: SHALL hold o_respN_valid=1 and stable res/err for the owner until i_respN_ready=1; on that edge update round-robin pointer to owner, go IDLE.
REQ-024 Non-owner o_resp*_valid SHALL be 0; o_respN_res/err are don't-care when valid=0 but SHALL be 0 after reset.
REQ-025 Minimum latency: accept at edge T0, ALU ready in ISSUE, result in first WAIT cycle -> o_respN_valid high in cycle T0+3.
REQ-026 A request valid while the FSM is busy SHALL wait with o_reqN_ready=0; requester must hold operands stable.
REQ-027 Wait counter width SHALL be clog2(TIMEOUT+1); no wrap-around permitted.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE from any state, aborting any in-flight operation with no response issued.
REQ-029 After reset: all o_reqN_ready, o_respN_valid, o_respN_err, o_alu_valid = 0; o_alu_a/b/cmd, o_respN_res = 0; counter = 0.
REQ-030 After reset, round-robin pointer SHALL indicate requester 1 as last granted, so requester 0 wins the first tie.

Structure
REQ-031 `DATA_WIDTH, ALU command codes and the four state encodings SHALL live in the shared header.v.
REQ-032 The ALU SHALL be instantiated outside this block; no sub-module required; round-robin grant logic kept inline.

Verification
REQ-033 Single op: req0 a=0x0F, b=0xF0, cmd=XOR, ALU ready and valid immediately -> o_resp0_valid at T0+3, res=0xFF, err=0.
REQ-034 Tie: req0 and req1 valid simultaneously, three back-to-back ops each -> grant order 0,1,0,1,0,1.
REQ-035 Backpressure: i_alu_ready low 5 cycles in ISSUE -> o_alu_valid and operands stable 5 cycles; i_resp0_ready low 4 cycles -> response held stable 4 cycles, req1 not accepted.
REQ-036 Timeout: ALU never asserts i_alu_valid, TIMEOUT=16 -> o_respN_valid with res=0, err=1 after 16 WAIT cycles; i_alu_valid on cycle 16 -> real result, err=0.
REQ-037 Reset mid-WAIT: reset pulse -> all outputs 0 next cycle, no response ever issued, next tie granted to requester 0.
